led_array_ctrl: RTL and testbench

Parametrised multi-channel LED driver and the successor to the single-bit, fixed-mode LED sub-block instantiated as an instance array. Each of NUM_CH raw inputs passes through its own synchroniser and debouncer. Each channel then drives its LED according to a mode selected at run time through a small register write port: off, direct, inverted or blinking. It sits between board-level switch/status inputs and the LED pins in the top level.

---
 rtl/led_array_ctrl.sv | 143 ++++++++++++++
 tb/tb_led_array_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/led_array_ctrl.sv
// Multi-channel LED driver: per-channel synchroniser + debouncer, run-time mode
// register per channel (off / direct / invert / blink), shared blink prescaler.

module led_ch #(
   parameter int DEBOUNCE     = 4,
   parameter int DEFAULT_MODE = 1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       val,
   input  logic       mode_we,
   input  logic [1:0] mode_data,
   input  logic       phase,
   output logic       led,
   output logic       stable,
   output logic       chg
);

   localparam int CW = $clog2(DEBOUNCE + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE - 1);

   typedef enum logic [1:0] {
      M_OFF    = 2'd0,
      M_DIRECT = 2'd1,
      M_INVERT = 2'd2,
      M_BLINK  = 2'd3
   } mode_t;

   logic          sync1, sync2;
   logic [CW-1:0] cnt, cnt_next;
   logic          stable_next;
   logic [1:0]    mode;

   // Counter only advances while the synchronised input disagrees with the
   // accepted level; any agreeing sample throws away the partial count.
   always_comb begin
      stable_next = stable;
      cnt_next    = cnt;
      if (sync2 == stable) begin
         cnt_next = '0;
      end else if (cnt == CNT_LAST) begin
         stable_next = sync2;
         cnt_next    = '0;
      end else begin
         cnt_next = cnt + 1'b1;
      end
   end

   assign chg = stable_next != stable;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1  <= 1'b0;
         sync2  <= 1'b0;
         stable <= 1'b0;
         cnt    <= '0;
         mode   <= 2'(DEFAULT_MODE);
         led    <= 1'b0;
      end else begin
         sync1  <= val;
         sync2  <= sync1;
         stable <= stable_next;
         cnt    <= cnt_next;
         if (mode_we) mode <= mode_data;
         // LED follows the registered mode/stable, so a same-edge mode write and
         // stable change are both visible one edge later.
         case (mode_t'(mode))
            M_OFF:    led <= 1'b0;
            M_DIRECT: led <= stable;
            M_INVERT: led <= ~stable;
            M_BLINK:  led <= stable & phase;
            default:  led <= 1'b0;
         endcase
      end
   end

endmodule

module led_array_ctrl #(
   parameter int NUM_CH       = 4,
   parameter int DEBOUNCE     = 4,
   parameter int BLINK_DIV    = 8,
   parameter int DEFAULT_MODE = 1,
   parameter int ADDR_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [NUM_CH-1:0] VAL,
   input  logic              MODE_WE,
   input  logic [ADDR_W-1:0] MODE_ADDR,
   input  logic [1:0]        MODE_DATA,
   output logic [NUM_CH-1:0] LED,
   output logic [NUM_CH-1:0] STABLE,
   output logic              EVENT
);

   localparam int PW = $clog2(BLINK_DIV);
   localparam logic [PW-1:0] PCNT_LAST = PW'(BLINK_DIV - 1);

   logic [PW-1:0]     pcnt;
   logic              phase;
   logic [NUM_CH-1:0] ch_we;
   logic [NUM_CH-1:0] chg;

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt  <= '0;
         phase <= 1'b0;
      end else if (pcnt == PCNT_LAST) begin
         pcnt  <= '0;
         phase <= ~phase;
      end else begin
         pcnt <= pcnt + 1'b1;
      end
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) EVENT <= 1'b0;
      else     EVENT <= |chg;
   end

   for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
      // Addresses at or above NUM_CH decode to no channel and are dropped.
      localparam logic [ADDR_W-1:0] IDX = ADDR_W'(i);
      assign ch_we[i] = MODE_WE && (MODE_ADDR == IDX);

      led_ch #(
         .DEBOUNCE    (DEBOUNCE),
         .DEFAULT_MODE(DEFAULT_MODE)
      ) u_ch (
         .clk      (CLK),
         .rst      (RST),
         .val      (VAL[i]),
         .mode_we  (ch_we[i]),
         .mode_data(MODE_DATA),
         .phase    (phase),
         .led      (LED[i]),
         .stable   (STABLE[i]),
         .chg      (chg[i])
      );
   end

endmodule

// File: tb/tb_led_array_ctrl.sv
// Bench for led_array_ctrl: table vectors, hand sequences for reset/glitch/blink/
// same-edge corners, and random traffic checked against a behavioural model.

module tb_led_array_ctrl;

   localparam int N = 4;
   localparam int D = 4;
   localparam int B = 8;

   logic         clk;
   logic         rst;
   logic [N-1:0] val;
   logic         mode_we;
   logic [1:0]   mode_addr;
   logic [1:0]   mode_data;
   logic [N-1:0] led;
   logic [N-1:0] stable;
   logic         event_o;

   logic [2:0]   val3;
   logic         we3;
   logic [1:0]   addr3;
   logic [1:0]   data3;
   logic [2:0]   led3;
   logic [2:0]   stable3;
   logic         event3;

   int errors = 0;
   int checks = 0;
   bit mon_en = 0;

   led_array_ctrl #(.NUM_CH(N), .DEBOUNCE(D), .BLINK_DIV(B), .DEFAULT_MODE(1)) u_dut (
      .CLK(clk), .RST(rst), .VAL(val), .MODE_WE(mode_we), .MODE_ADDR(mode_addr),
      .MODE_DATA(mode_data), .LED(led), .STABLE(stable), .EVENT(event_o)
   );

   led_array_ctrl #(.NUM_CH(3), .DEBOUNCE(D), .BLINK_DIV(B), .DEFAULT_MODE(1)) u_dut3 (
      .CLK(clk), .RST(rst), .VAL(val3), .MODE_WE(we3), .MODE_ADDR(addr3),
      .MODE_DATA(data3), .LED(led3), .STABLE(stable3), .EVENT(event3)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model. vh holds VAL as sampled at past edges (newest first); a
   // channel accepts a new level when the last D samples the debouncer saw
   // (VAL two edges back and older) all disagree with the accepted level.
   logic [N-1:0] vh[$];
   logic [N-1:0] m_stable, m_led, m_nxt;
   logic         m_event;
   logic [1:0]   m_mode[N];
   int           m_cyc;
   bit           m_ph, m_flip;

   initial forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
         vh.delete();
         for (int j = 0; j <= D; j++) vh.push_back('0);
         m_stable = '0; m_led = '0; m_event = 0; m_cyc = 0;
         for (int c = 0; c < N; c++) m_mode[c] = 2'd1;
      end else begin
         m_ph  = ((m_cyc / B) % 2) == 1;
         m_nxt = m_stable;
         for (int c = 0; c < N; c++) begin
            m_flip = 1;
            for (int j = 1; j <= D; j++) if (vh[j][c] == m_stable[c]) m_flip = 0;
            if (m_flip) m_nxt[c] = ~m_stable[c];
            case (m_mode[c])
               2'd0: m_led[c] = 1'b0;
               2'd1: m_led[c] = m_stable[c];
               2'd2: m_led[c] = ~m_stable[c];
               default: m_led[c] = m_stable[c] & m_ph;
            endcase
         end
         if (mode_we) m_mode[mode_addr] = mode_data;
         m_event  = m_nxt != m_stable;
         m_stable = m_nxt;
         vh.push_front(val);
         void'(vh.pop_back());
         m_cyc++;
      end
   end

   always @(negedge clk) begin
      if (mon_en) begin
         chk("mon_led", led, m_led);
         chk("mon_stable", stable, m_stable);
         chk("mon_event", event_o, m_event);
      end
   end

   task automatic wr(input logic [1:0] a, input logic [1:0] d);
      @(negedge clk);
      mode_we = 1; mode_addr = a; mode_data = d;
      @(negedge clk);
      mode_we = 0;
   endtask

   typedef struct {
      logic [N-1:0] v;
      logic [7:0]   modes;   // {ch3, ch2, ch1, ch0}
      logic [N-1:0] exp_led;
   } vec_t;

   vec_t tv[6];

   initial begin
      int  r1, r2, f1;
      bit  prev, seen;
      tv[0] = '{4'hF, 8'b01_01_01_01, 4'hF};
      tv[1] = '{4'h5, 8'b01_01_01_01, 4'h5};
      tv[2] = '{4'h5, 8'b10_10_10_10, 4'hA};
      tv[3] = '{4'h5, 8'b10_10_01_00, 4'h8};
      tv[4] = '{4'h3, 8'b01_01_00_10, 4'h0};
      tv[5] = '{4'hC, 8'b01_01_10_10, 4'hF};

      rst = 1; val = 4'hF; mode_we = 0; mode_addr = 0; mode_data = 0;
      val3 = 3'b111; we3 = 0; addr3 = 0; data3 = 0;
      #1;
      chk("rst_led", led, 0);
      chk("rst_stable", stable, 0);
      chk("rst_event", event_o, 0);
      repeat (2) @(negedge clk);
      rst = 0;
      mon_en = 1;
      // First edge after release samples VAL: STABLE at edge 2+D, LED one later.
      for (int e = 1; e <= D + 3; e++) begin
         @(posedge clk); #1;
         if (e == D + 1) chk("rel_stable_early", stable, 4'h0);
         if (e == D + 2) begin chk("rel_stable", stable, 4'hF); chk("rel_event", event_o, 1); end
         if (e == D + 3) begin chk("rel_led", led, 4'hF); chk("rel_event_drop", event_o, 0); end
      end

      // Glitch rejection on ch2
      val = 4'h0;
      repeat (10) @(negedge clk);
      val[2] = 1;
      repeat (3) @(negedge clk);
      val[2] = 0;
      seen = 0;
      repeat (12) begin @(negedge clk); if (event_o || stable[2]) seen = 1; end
      chk("glitch3_reject", seen, 0);
      val[2] = 1;
      repeat (4) @(negedge clk);
      val[2] = 0;
      seen = 0;
      repeat (10) begin @(negedge clk); if (stable[2]) seen = 1; end
      chk("glitch4_pass", seen, 1);
      repeat (10) @(negedge clk);

      // Table-driven mode/value vectors
      for (int t = 0; t < 6; t++) begin
         for (int c = 0; c < N; c++) wr(2'(c), tv[t].modes[2*c +: 2]);
         val = tv[t].v;
         repeat (D + 6) @(negedge clk);
         chk($sformatf("tv%0d_stable", t), stable, tv[t].v);
         chk($sformatf("tv%0d_led", t), led, tv[t].exp_led);
      end

      // Blink on ch3 (stable 1): period 2*B, high for B
      wr(2'd3, 2'd3);
      r1 = -1; r2 = -1; f1 = -1; prev = led[3];
      for (int c = 0; c < 100 && r2 < 0; c++) begin
         @(negedge clk);
         if (led[3] && !prev) begin if (r1 < 0) r1 = c; else r2 = c; end
         if (!led[3] && prev && r1 >= 0 && f1 < 0) f1 = c;
         prev = led[3];
      end
      chk("blink_period", r2 - r1, 2 * B);
      chk("blink_high", f1 - r1, B);

      // Same-edge mode write and stable rise on ch0
      wr(2'd0, 2'd1);
      @(negedge clk); val[0] = 1;
      repeat (D + 1) @(negedge clk);
      mode_we = 1; mode_addr = 0; mode_data = 2;
      @(posedge clk); #1;
      chk("simul_stable", stable[0], 1);
      chk("simul_event", event_o, 1);
      chk("simul_led_old", led[0], 0);
      @(negedge clk); mode_we = 0;
      @(posedge clk); #1;
      chk("simul_led_new", led[0], 0);
      chk("simul_event_drop", event_o, 0);
      val[0] = 0;
      repeat (12) @(negedge clk);

      // Reset while ch1 sits at cnt=D-1 and ch3 is blinking
      val = 4'hC;
      repeat (10) @(negedge clk);
      val[1] = 1;
      repeat (D + 1) @(negedge clk);
      #1 rst = 1;
      #1;
      chk("mid_rst_led", led, 0);
      chk("mid_rst_stable", stable, 0);
      @(negedge clk);
      rst = 0;
      for (int e = 1; e <= 2 * B + 1; e++) begin
         @(posedge clk); #1;
         mode_we = 0;
         if (e == D + 1) chk("mid_ch1_early", stable, 4'h0);
         if (e == D + 2) chk("mid_ch1_full", stable, 4'hE);
         if (e == D + 3) begin
            chk("mid_default_mode", led, 4'hE);
            mode_we = 1; mode_addr = 3; mode_data = 3;
         end
         if (e == 2 * B) chk("mid_phase_hi", led[3], 1);
         if (e == 2 * B + 1) chk("mid_phase_lo", led[3], 0);
      end

      // Random traffic against the model
      for (int i = 0; i < 2000; i++) begin
         @(negedge clk);
         if ($urandom_range(5) == 0) val = 4'($urandom);
         else if ($urandom_range(3) == 0) val[$urandom_range(N - 1)] ^= 1'b1;
         mode_we   = ($urandom_range(3) == 0);
         mode_addr = 2'($urandom);
         mode_data = 2'($urandom);
      end
      @(negedge clk); mode_we = 0;

      // Three-channel instance: address 3 is out of range
      chk("n3_led_init", led3, 3'b111);
      @(negedge clk); we3 = 1; addr3 = 3; data3 = 0;
      @(negedge clk); we3 = 0;
      repeat (3) @(negedge clk);
      chk("n3_badaddr_led", led3, 3'b111);
      chk("n3_badaddr_stable", stable3, 3'b111);
      chk("n3_badaddr_event", event3, 0);
      we3 = 1; addr3 = 1; data3 = 2;
      @(negedge clk); we3 = 0;
      chk("n3_wr_same_edge", led3, 3'b111);
      @(negedge clk);
      chk("n3_wr_next_edge", led3, 3'b101);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
